// File: rtl/scpu_trace_monitor.sv
// Commit-trace monitor: turns each enabled clock edge of the single-cycle CPU
// into a commit record, queues records in a small FIFO drained over
// valid/ready, and tracks retirement count, drops and program-end.
module scpu_trace_monitor #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HALT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] PC,
  input  logic [31:0] newPC,
  input  logic [31:0] instruct,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [31:0] ReadData2,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_instr,
  output logic [1:0]  rec_kind,
  output logic [31:0] rec_data,
  output logic [31:0] retired,
  output logic [15:0] dropped,
  output logic        overflow,
  output logic        halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HC_W  = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [31:0] data;
  } rec_t;

  state_t            state, state_next;
  logic [HC_W-1:0]   hcnt;
  rec_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic sample, match, halt_done;
  logic full, pop, push_ok, drop;
  rec_t new_rec;

  assign match     = (newPC == PC);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = rec_valid && rec_ready;
  assign push_ok   = sample && (!full || pop);
  assign drop      = sample && full && !pop;

  // Record content for the current sample; stores carry rt, writes carry WB value
  always_comb begin
    new_rec       = '0;
    new_rec.pc    = PC;
    new_rec.instr = instruct;
    new_rec.kind  = {MemWrite, RegWrite};
    if (RegWrite)
      new_rec.data = WriteData;
    else if (MemWrite)
      new_rec.data = ReadData2;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus sample/halt decisions; the IDLE->RUN edge also samples
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    halt_done  = 1'b0;
    case (state)
      IDLE, RUN: begin
        sample     = en;
        halt_done  = en && match && (hcnt == HC_W'(HALT_CYCLES - 1));
        if (halt_done)  state_next = HALT;
        else if (en)    state_next = RUN;
        else            state_next = IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Consecutive self-loop counter; holds across en=0 gaps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        hcnt <= '0;
    else if (sample) hcnt <= match ? hcnt + 1'b1 : '0;
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Retirement, drop and halt bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired  <= '0;
      dropped  <= '0;
      overflow <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (sample) retired <= retired + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 1'b1;
      end
      if (halt_done) halted <= 1'b1;
    end
  end

  assign rec_valid = (count != '0);
  assign rec_pc    = mem[rd_ptr].pc;
  assign rec_instr = mem[rd_ptr].instr;
  assign rec_kind  = mem[rd_ptr].kind;
  assign rec_data  = mem[rd_ptr].data;

endmodule

// File: tb/tb_scpu_trace_monitor.sv
// Directed bench for scpu_trace_monitor (DEPTH=4, HALT_CYCLES=2).
module tb_scpu_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] PC, newPC, instruct, WriteData, ReadData2;
  logic        RegWrite, MemWrite;
  logic        rec_valid, rec_ready;
  logic [31:0] rec_pc, rec_instr, rec_data, retired;
  logic [1:0]  rec_kind;
  logic [15:0] dropped;
  logic        overflow, halted;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  scpu_trace_monitor #(.DEPTH(4), .HALT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .PC(PC), .newPC(newPC), .instruct(instruct),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .WriteData(WriteData),
    .ReadData2(ReadData2), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pc(rec_pc), .rec_instr(rec_instr), .rec_kind(rec_kind),
    .rec_data(rec_data), .retired(retired), .dropped(dropped),
    .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] npc,
                       input logic rw, input logic mw,
                       input logic [31:0] wd, input logic [31:0] rd2);
    PC = pc; newPC = npc; instruct = pc ^ 32'hA5A5_0000;
    RegWrite = rw; MemWrite = mw; WriteData = wd; ReadData2 = rd2;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; rec_ready = 1'b0;
    drive(32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    check("rst_valid", {31'd0, rec_valid}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_kind", {30'd0, rec_kind}, 32'd0);
    check("rst_pc", rec_pc, 32'd0);
    rst = 1'b1;
    step();

    // three register-write retirements, drained as they arrive
    rec_ready = 1'b1; en = 1'b1;
    drive(32'h0, 32'h4, 1'b1, 1'b0, 32'd5, 32'h0);
    step();
    check("r0_valid", {31'd0, rec_valid}, 32'd1);
    check("r0_pc", rec_pc, 32'h0);
    check("r0_kind", {30'd0, rec_kind}, 32'd1);
    check("r0_data", rec_data, 32'd5);
    check("r0_instr", rec_instr, 32'hA5A5_0000);
    drive(32'h4, 32'h8, 1'b1, 1'b0, 32'd6, 32'h0);
    step();
    check("r1_pc", rec_pc, 32'h4);
    check("r1_data", rec_data, 32'd6);
    drive(32'h8, 32'hC, 1'b1, 1'b0, 32'd7, 32'h0);
    step();
    check("r2_pc", rec_pc, 32'h8);
    check("r2_data", rec_data, 32'd7);
    check("r2_retired", retired, 32'd3);
    check("r2_halted", {31'd0, halted}, 32'd0);
    en = 1'b0;
    step();
    check("r_drained", {31'd0, rec_valid}, 32'd0);

    // store record
    rec_ready = 1'b0; en = 1'b1;
    drive(32'h10, 32'h14, 1'b0, 1'b1, 32'h1234, 32'hDEADBEEF);
    step();
    check("st_kind", {30'd0, rec_kind}, 32'd2);
    check("st_data", rec_data, 32'hDEADBEEF);
    check("st_pc", rec_pc, 32'h10);
    check("st_retired", retired, 32'd4);
    en = 1'b0; rec_ready = 1'b1;
    step();
    check("st_drained", {31'd0, rec_valid}, 32'd0);

    // overflow: six samples into a four-entry FIFO with no consumer
    rec_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 1'b1, 1'b0, 32'(100 + i), 32'h0);
      step();
    end
    check("ov_dropped", {16'd0, dropped}, 32'd2);
    check("ov_flag", {31'd0, overflow}, 32'd1);
    check("ov_retired", retired, 32'd10);
    check("ov_hold_pc", rec_pc, 32'h100);
    en = 1'b0; rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ov_drain_pc", rec_pc, 32'h100 + 32'(4 * i));
      check("ov_drain_data", rec_data, 32'(100 + i));
      step();
    end
    check("ov_empty", {31'd0, rec_valid}, 32'd0);

    // full FIFO with simultaneous pop and push
    rec_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 1'b1, 1'b0, 32'(200 + i), 32'h0);
      step();
    end
    check("fp_full_dropped", {16'd0, dropped}, 32'd2);
    rec_ready = 1'b1;
    drive(32'h210, 32'h214, 1'b1, 1'b0, 32'd204, 32'h0);
    step();
    check("fp_dropped", {16'd0, dropped}, 32'd2);
    check("fp_retired", retired, 32'd15);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fp_drain_pc", rec_pc, 32'h204 + 32'(4 * i));
      step();
    end
    check("fp_empty", {31'd0, rec_valid}, 32'd0);

    // halt detection with a mismatch restart and an en=0 gap
    en = 1'b1;
    drive(32'h20, 32'h20, 1'b1, 1'b0, 32'h1, 32'h0);
    step();
    check("h1_retired", retired, 32'd16);
    check("h1_halted", {31'd0, halted}, 32'd0);
    drive(32'h24, 32'h28, 1'b1, 1'b0, 32'h2, 32'h0);
    step();
    check("h2_pc", rec_pc, 32'h24);
    check("h2_retired", retired, 32'd17);
    rec_ready = 1'b0;
    drive(32'h20, 32'h20, 1'b1, 1'b0, 32'h3, 32'h0);
    step();
    check("h3_halted", {31'd0, halted}, 32'd0);
    check("h3_retired", retired, 32'd18);
    en = 1'b0;
    step();
    check("hgap_halted", {31'd0, halted}, 32'd0);
    en = 1'b1;
    step();
    check("h4_halted", {31'd0, halted}, 32'd1);
    check("h4_retired", retired, 32'd19);
    step();
    step();
    check("hpost_retired", retired, 32'd19);
    check("hpost_pc", rec_pc, 32'h24);
    check("hpost_valid", {31'd0, rec_valid}, 32'd1);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", {31'd0, rec_valid}, 32'd0);
    check("ar_retired", retired, 32'd0);
    check("ar_halted", {31'd0, halted}, 32'd0);
    check("ar_overflow", {31'd0, overflow}, 32'd0);
    check("ar_dropped", {16'd0, dropped}, 32'd0);
    check("ar_pc", rec_pc, 32'd0);
    #2;
    rst = 1'b1;

    // sampling resumes from IDLE; kinds 00 and 11
    en = 1'b1; rec_ready = 1'b0;
    drive(32'h40, 32'h44, 1'b0, 1'b0, 32'h77, 32'h88);
    step();
    check("k0_kind", {30'd0, rec_kind}, 32'd0);
    check("k0_data", rec_data, 32'd0);
    check("k0_retired", retired, 32'd1);
    drive(32'h44, 32'h48, 1'b1, 1'b1, 32'h55, 32'h66);
    step();
    en = 1'b0; rec_ready = 1'b1;
    step();
    check("k3_kind", {30'd0, rec_kind}, 32'd3);
    check("k3_data", rec_data, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scpu_trace_monitor.md
# scpu_trace_monitor

Commit-trace monitor on the observation side of the single-cycle CPU. It samples the CPU's per-cycle debug outputs and treats each enabled clock edge as one retired instruction. Each retirement becomes a commit record, buffered in a small FIFO and drained over a valid/ready interface. It also keeps a retirement count, detects program end (self-loop jump), and flags records lost to backpressure.

## Interface

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- HALT_CYCLES, 2, consecutive self-loop samples (newPC == PC) that declare halt (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  sample enable; high while the CPU is running
- PC  in  32  current instruction address
- newPC  in  32  next PC computed this cycle
- instruct  in  32  current instruction word
- RegWrite  in  1  register-file write this cycle
- MemWrite  in  1  data-memory write this cycle
- WriteData  in  32  register write-back value
- ReadData2  in  32  store data (rt value)
- rec_valid  out  1  FIFO head holds a record
- rec_ready  in  1  consumer accepts the head
- rec_pc  out  32  record PC
- rec_instr  out  32  record instruction word
- rec_kind  out  2  00 none, 01 reg write, 10 mem write, 11 both
- rec_data  out  32  record payload
- retired  out  32  retired-instruction count
- dropped  out  16  records lost to a full FIFO
- overflow  out  1  sticky: at least one drop
- halted  out  1  sticky: program-end detected

## Operation

- FSM states and transitions:
  - IDLE: en=0.
    - IDLE→RUN when en=1 (the sample on that same edge is taken).
  - RUN: sample on every edge with en=1.
    - RUN→IDLE when en=0.
    - RUN→HALT when the HALT_CYCLES-th consecutive newPC==PC sample is taken.
  - HALT: absorbing until reset. No sampling; the FIFO keeps draining.
- Sample content:
  - RegWrite=1, MemWrite=0: kind 01, data = WriteData.
  - RegWrite=0, MemWrite=1: kind 10, data = ReadData2.
  - Both set: kind 11, data = WriteData.
  - Neither set: kind 00, data = 0.
  - rec_pc = PC; rec_instr = instruct.
- Every sample increments retired (wraps 2^32−1→0) and pushes one record.
- Halt counter:
  - Increments on each sample with newPC==PC.
  - Clears on any sample with newPC!=PC.
  - Holds while en=0, so the consecutive count spans IDLE gaps.
- The sample that completes the halt count is counted and recorded; later samples are not.
- FIFO push/pop:
  - Pop when rec_valid && rec_ready.
  - Push when a sample is taken.
  - Full with simultaneous pop: the push succeeds and occupancy is unchanged.
  - Full without pop: record dropped; dropped increments (saturates at 16'hFFFF); overflow sets. retired still increments.
  - Empty with simultaneous push: no pop occurs; the record appears on the next cycle.
- Reset (asynchronous, any time, including mid-drain or mid-halt-count):
  - FIFO emptied; rec_valid=0.
  - rec_pc, rec_instr, rec_data = 0; rec_kind = 00.
  - retired = 0, dropped = 0, overflow = 0, halted = 0.
  - Halt counter = 0; state = IDLE.

## Timing

- All outputs are registered or driven directly from the FIFO head register/RAM read of a registered pointer. There are no combinational paths from inputs to outputs.
- Push latency: a sample taken on edge N into an empty FIFO gives rec_valid=1 from edge N onward (visible in cycle N+1).
- Handshake: while rec_valid=1 && rec_ready=0, rec_* hold stable. rec_valid never drops without a pop or reset.
- Back-to-back: with rec_ready held high, one record per cycle; throughput equals the sample rate.
- Counter updates:
  - retired and dropped update on the sampling edge.
  - halted rises on the edge that takes the completing sample.
  - overflow rises on the edge of the first drop.

## Test plan

- Reset release, en=1, 3 cycles, with rec_ready=1:
  - PC 0,4,8; RegWrite=1; WriteData 5,6,7; newPC=PC+4.
  - Expect three records: kind 01, data 5/6/7, in order.
  - Expect retired=3, halted=0.
- Store record:
  - MemWrite=1, RegWrite=0, ReadData2=32'hDEADBEEF, PC=32'h10.
  - Expect rec_kind=10, rec_data=32'hDEADBEEF, rec_pc=32'h10.
- Overflow:
  - rec_ready=0, DEPTH=4, 6 samples.
  - Expect 4 records held, dropped=2, overflow=1, retired=6.
  - Then raise rec_ready: exactly the first 4 records drain, then rec_valid=0.
- Full with simultaneous pop:
  - FIFO full, rec_ready=1 and a sample on the same edge.
  - Expect dropped unchanged; occupancy stays 4; head advances.
- Halt, HALT_CYCLES=2:
  - newPC==PC=32'h20 on two samples with one en=0 cycle between.
  - Expect halted=1 after the second sample and retired counting both.
  - Further en=1 cycles leave retired unchanged.
  - A mismatch between matches restarts the count.
- Asynchronous reset mid-operation:
  - Assert rst=0 between edges with 3 records queued and halted=1.
  - Expect immediate rec_valid=0, retired=0, halted=0, overflow=0.
